// File: rtl/program_loader.sv
// Byte-stream program loader: holds the CPU in reset, packs bytes big-endian into
// 32-bit words written to instruction memory from address 0, then releases the CPU.
module program_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            byte_cnt_r;
  logic [31:0]           asm_r;
  logic [7:0]            hold_cnt_r;
  logic [ADDR_WIDTH:0]   word_count_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic                  cpu_reset_r;
  logic                  done_r;
  logic                  error_r;

  logic                  accept_s;
  logic                  emit_s;
  logic                  overflow_s;
  logic                  write_s;
  logic [31:0]           word_s;

  // Ready is gated by reset so no byte is taken while the loader is being cleared.
  assign in_ready   = (state_r == LOAD) && !reset;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD: begin
        if (overflow_s) begin
          state_s = ERR;
        end else if (accept_s && in_last) begin
          state_s = HOLD;
        end else begin
          state_s = LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s = RUN;
        end else begin
          state_s = HOLD;
        end
      end
      RUN:     state_s = RUN;
      ERR:     state_s = ERR;
      default: state_s = LOAD;
    endcase
  end

  // Byte acceptance, word completion and overflow decode; unfilled low bytes stay zero
  always_comb begin
    accept_s   = in_valid & in_ready;
    emit_s     = accept_s & ((byte_cnt_r == 2'd3) | in_last);
    overflow_s = emit_s & (word_count_r == DEPTH_W);
    write_s    = emit_s & ~overflow_s;
    word_s     = asm_r | ({in_byte, 24'h000000} >> {byte_cnt_r, 3'b000});
  end

  // Assembly datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_r   <= 2'd0;
      asm_r        <= 32'h0000_0000;
      hold_cnt_r   <= 8'd0;
      word_count_r <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      cpu_reset_r  <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        if (emit_s) begin
          byte_cnt_r <= 2'd0;
          asm_r      <= 32'h0000_0000;
        end else begin
          byte_cnt_r <= byte_cnt_r + 2'd1;
          asm_r      <= word_s;
        end
      end
      if (write_s) begin
        mem_addr_r   <= word_count_r[ADDR_WIDTH-1:0];
        mem_wdata_r  <= word_s;
        word_count_r <= word_count_r + ONE_W;
      end
      hold_cnt_r  <= (state_r == HOLD) ? hold_cnt_r + 8'd1 : 8'd0;
      mem_we_r    <= write_s;
      cpu_reset_r <= (state_s != RUN);
      done_r      <= (state_s == RUN);
      error_r     <= (state_s == ERR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default instance (ADDR_WIDTH=6) and a small
// instance (ADDR_WIDTH=2) share one stimulus stream; writes are logged per instance.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last  = 1'b0;
  logic [7:0] in_byte  = 8'h00;

  logic        in_ready, mem_we, cpu_reset, done, error;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_count;

  logic        in_ready_s, mem_we_s, cpu_reset_s, done_s, error_s;
  logic [1:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [2:0]  word_count_s;

  program_loader #(.ADDR_WIDTH(6), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .word_count(word_count)
  );

  program_loader #(.ADDR_WIDTH(2), .HOLD_CYCLES(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_byte(in_byte), .in_last(in_last), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .cpu_reset(cpu_reset_s), .done(done_s), .error(error_s),
    .word_count(word_count_s)
  );

  int checks = 0;
  int errors = 0;

  // Write logs: every memory write of each instance in order
  int          wcnt   = 0;
  int          wcnt_s = 0;
  logic [5:0]  log_addr   [64];
  logic [31:0] log_data   [64];
  logic [1:0]  log_addr_s [64];
  logic [31:0] log_data_s [64];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr[wcnt[5:0]] <= mem_addr;
      log_data[wcnt[5:0]] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
    if (mem_we_s === 1'b1) begin
      log_addr_s[wcnt_s[5:0]] <= mem_addr_s;
      log_data_s[wcnt_s[5:0]] <= mem_wdata_s;
      wcnt_s <= wcnt_s + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called right after the in_last byte was accepted at edge k: release lands on edge k+4
  task automatic check_release(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_hold_done"}, 64'(done), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_rel_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({tag, "_rel_done"}, 64'(done), 64'd1);
  endtask

  logic [7:0] prog_a [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
  logic [7:0] prog_b [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] prog_c [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    int base;
    int base_s;

    // Reset values
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready2", 64'(in_ready), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready_after", 64'(in_ready), 64'd1);

    // Two full words, with single-cycle write strobe timing
    base = wcnt;
    for (int i = 0; i < 4; i++) send_byte(prog_a[i], 1'b0);
    check("w0_we", 64'(mem_we), 64'd1);
    check("w0_addr", 64'(mem_addr), 64'd0);
    check("w0_data", 64'(mem_wdata), 64'h20080005);
    @(posedge clk);
    #1;
    check("w0_we_pulse", 64'(mem_we), 64'd0);
    for (int i = 4; i < 8; i++) send_byte(prog_a[i], i == 7);
    check("full_in_ready_hold", 64'(in_ready), 64'd0);
    check_release("full");
    check("full_wcnt", 64'(wcnt - base), 64'd2);
    check("full_a0", {26'd0, log_addr[base[5:0]], log_data[base[5:0]]}, {26'd0, 6'd0, 32'h20080005});
    check("full_a1", {26'd0, log_addr[base[5:0] + 6'd1], log_data[base[5:0] + 6'd1]}, {26'd0, 6'd1, 32'h20090007});
    check("full_word_count", 64'(word_count), 64'd2);

    // Partial final word is zero-padded
    do_reset(1);
    base = wcnt;
    for (int i = 0; i < 6; i++) send_byte(prog_b[i], i == 5);
    check_release("part");
    check("part_wcnt", 64'(wcnt - base), 64'd2);
    check("part_a0", {26'd0, log_addr[base[5:0]], log_data[base[5:0]]}, {26'd0, 6'd0, 32'hAABBCCDD});
    check("part_a1", {26'd0, log_addr[base[5:0] + 6'd1], log_data[base[5:0] + 6'd1]}, {26'd0, 6'd1, 32'h11220000});

    // Gapped stream, then bytes driven while running are ignored
    do_reset(1);
    base = wcnt;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      send_byte(prog_a[i], i == 7);
    end
    check_release("gap");
    for (int i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i), i == 5);
    repeat (2) @(posedge clk);
    #1;
    check("gap_wcnt", 64'(wcnt - base), 64'd2);
    check("gap_a0", {26'd0, log_addr[base[5:0]], log_data[base[5:0]]}, {26'd0, 6'd0, 32'h20080005});
    check("gap_a1", {26'd0, log_addr[base[5:0] + 6'd1], log_data[base[5:0] + 6'd1]}, {26'd0, 6'd1, 32'h20090007});
    check("gap_word_count", 64'(word_count), 64'd2);
    check("gap_done", 64'(done), 64'd1);

    // Overflow on the small instance: the 5th word sets error with no write
    do_reset(1);
    base_s = wcnt_s;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i + 1), 1'b0);
      if (i == 15) begin
        check("ovf_at_depth_error", 64'(error_s), 64'd0);
        check("ovf_at_depth_count", 64'(word_count_s), 64'd4);
      end
    end
    check("ovf_error", 64'(error_s), 64'd1);
    check("ovf_in_ready", 64'(in_ready_s), 64'd0);
    check("ovf_mem_we", 64'(mem_we_s), 64'd0);
    check("ovf_cpu_reset", 64'(cpu_reset_s), 64'd1);
    @(posedge clk);
    #1;
    check("ovf_wcnt", 64'(wcnt_s - base_s), 64'd4);
    check("ovf_a0", {30'd0, log_addr_s[base_s[5:0]], log_data_s[base_s[5:0]]}, {30'd0, 2'd0, 32'h01020304});
    check("ovf_a3", {30'd0, log_addr_s[base_s[5:0] + 6'd3], log_data_s[base_s[5:0] + 6'd3]}, {30'd0, 2'd3, 32'h0D0E0F10});
    check("ovf_sticky_error", 64'(error_s), 64'd1);
    check("ovf_done", 64'(done_s), 64'd0);

    // Exactly DEPTH words ending in in_last is legal on the small instance
    do_reset(1);
    base_s = wcnt_s;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), i == 15);
    repeat (4) @(posedge clk);
    #1;
    check("exact_error", 64'(error_s), 64'd0);
    check("exact_done", 64'(done_s), 64'd1);
    check("exact_cpu_reset", 64'(cpu_reset_s), 64'd0);
    check("exact_wcnt", 64'(wcnt_s - base_s), 64'd4);
    check("exact_a3", {30'd0, log_addr_s[base_s[5:0] + 6'd3], log_data_s[base_s[5:0] + 6'd3]}, {30'd0, 2'd3, 32'h4C4D4E4F});

    // Reset mid-load discards the partial word
    do_reset(1);
    for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i), 1'b0);
    do_reset(1);
    #1;
    check("mid_word_count_clr", 64'(word_count), 64'd0);
    check("mid_cpu_reset", 64'(cpu_reset), 64'd1);
    base = wcnt;
    for (int i = 0; i < 4; i++) send_byte(prog_c[i], i == 3);
    check_release("mid");
    check("mid_wcnt", 64'(wcnt - base), 64'd1);
    check("mid_a0", {26'd0, log_addr[base[5:0]], log_data[base[5:0]]}, {26'd0, 6'd0, 32'h12345678});
    check("mid_word_count", 64'(word_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that sits upstream of the instruction fetch unit and instruction memory. It holds the processor in reset, assembles an incoming byte stream into big-endian 32-bit instruction words, and writes them to consecutive word addresses from 0. After the last byte and a fixed hold interval, it releases the processor. Testbenches use it to boot programs such as fefe, memset and the branch/jump suites through the real memory write port instead of `$readmemh`.

## Interface
- `ADDR_WIDTH`, default 6: instruction memory word-address width; capacity DEPTH = 2**ADDR_WIDTH words.
- `HOLD_CYCLES`, default 4: number of cycles `cpu_reset` stays high after the final write; legal range 1..255.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `in_valid`  in  1: `in_byte` is valid this cycle.
- `in_ready`  out  1: loader accepts a byte this cycle. A byte is accepted when `in_valid & in_ready` at a rising edge.
- `in_byte`  in  8: program byte; the first byte of each word goes to bits 31:24.
- `in_last`  in  1: qualifies the accepted byte as the final byte of the program.
- `mem_we`  out  1: one-cycle write strobe to instruction memory.
- `mem_addr`  out  ADDR_WIDTH: word address for the write.
- `mem_wdata`  out  32: word to write.
- `cpu_reset`  out  1: reset to the processor (IFU/PC and register file); high while loading.
- `done`  out  1: program loaded and processor released.
- `error`  out  1: overflow; the program exceeded DEPTH words.
- `word_count`  out  ADDR_WIDTH+1: number of words written so far.

## Operation
- States:
  - LOAD: `in_ready`=1.
  - HOLD: `in_ready`=0; `cpu_reset`=1; counter runs.
  - RUN: `done`=1; `cpu_reset`=0.
  - ERROR: `error`=1; `cpu_reset`=1.
- Reset moves the block to LOAD, clears `byte_cnt` (2 bits) and `word_count`, and zeroes the assembly register.
- Each accepted byte is shifted into the assembly register at position 31-8*`byte_cnt`, and `byte_cnt` increments.
- A word is emitted when an accepted byte has `byte_cnt`==3 or `in_last`=1:
  - Unfilled low bytes are zero-padded.
  - `mem_we`=1, `mem_addr`=`word_count`[ADDR_WIDTH-1:0], `mem_wdata`=the word.
  - `word_count` increments and `byte_cnt` returns to 0.
- An accepted byte with `in_last`=1 moves LOAD to HOLD (after the final write), and the hold counter is loaded with 0.
- HOLD to RUN when the hold counter reaches HOLD_CYCLES-1.
- Overflow: if a word is emitted while `word_count`==DEPTH, no write occurs and the block enters ERROR. ERROR is sticky until `reset`.
  - Exactly DEPTH words, the last carrying `in_last`, is legal.
- RUN and ERROR ignore all input. `in_valid` while `in_ready`=0 has no effect.

## Timing
- Every output is registered except `in_ready`, which decodes the state register.
- Values during and immediately after reset: `in_ready`=0 while `reset` is high, then 1 from the first cycle after reset deasserts. `cpu_reset`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `error`=0, `word_count`=0.
- Write latency: the byte completing a word is accepted at edge k, and `mem_we`/`mem_addr`/`mem_wdata` are valid in the cycle following edge k, for exactly one cycle. Memory captures the write at edge k+1.
- There is no backpressure from memory, so back-to-back words can write on consecutive 4-cycle boundaries.
- The `in_last` byte is accepted at edge k:
  - The state is HOLD from edge k.
  - `cpu_reset` falls and `done` rises at edge k+HOLD_CYCLES.
  - The final write (edge k+1) always precedes release.
- The overflow byte is accepted at edge k: `error`=1 and `in_ready`=0 from edge k, and `mem_we` stays 0.
- Reset mid-operation, in any state:
  - At that edge, `cpu_reset` returns to 1, `done`/`error`/`mem_we` go to 0, and counts clear.
  - A partially assembled word is discarded.

## Test plan
- Reset check: assert `reset` for 2 cycles -> all outputs hold their reset values; `in_ready`=1 in the cycle after release.
- Two full words: bytes 20 08 00 05 20 09 00 07, `in_last` on the 8th -> addr0=0x20080005 and addr1=0x20090007, one `mem_we` pulse each; `word_count`=2; `cpu_reset` falls exactly 4 edges after the last byte is accepted; `done`=1.
- Partial word: bytes AA BB CC DD 11 22, `in_last` on 0x22 -> addr0=0xAABBCCDD, addr1=0x11220000, then release.
- Gapped stream: same bytes as the two-full-words case with `in_valid` low for 1-3 random cycles between bytes, and bytes driven in RUN afterwards -> identical writes; no writes after `done`.
- Overflow (`ADDR_WIDTH`=2): 20 bytes, no `in_last` -> 4 writes to addr0..3; the 20th byte sets `error`=1 with no write; `cpu_reset` stays 1; `in_ready`=0.
- Reset mid-load: 5 bytes, then `reset` for 1 cycle, then 12 34 56 78 with `in_last` -> only addr0=0x12345678 is written after reset; `word_count`=1; release after 4 edges.
